// File: rtl/mul_result_buffer.sv
// Result FIFO behind the pipelined multiplier; freezes the multiplier via mult_clk_en_o when full.
// Optional same-cycle empty bypass is enabled by defining MUL_RESULT_BYPASS_EN.
module mul_result_buffer #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic [2*DATA_WIDTH-1:0]          mult_result_i,
    input  logic                             mult_valid_i,
    output logic                             mult_clk_en_o,
    output logic [2*DATA_WIDTH-1:0]          res_data_o,
    output logic                             res_valid_o,
    input  logic                             res_ready_i,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  count_o,
    output logic                             full_o
);

    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FIFO_DEPTH);

    logic [PROD_W-1:0] mem_q [FIFO_DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q,  count_d;
    logic             full_q,   full_d;
    logic             valid_q,  valid_d;
    logic             clk_en_q, clk_en_d;

    logic bypass_c;
    logic push_c;
    logic pop_c;

    // Empty-FIFO bypass: a product offered to a ready consumer skips storage entirely.
`ifdef MUL_RESULT_BYPASS_EN
    assign bypass_c = !valid_q && mult_valid_i && res_ready_i;
`else
    assign bypass_c = 1'b0;
`endif

    // A frozen product (enable low) is never pushed, so it cannot be duplicated.
    always_comb begin
        push_c   = 1'b0;
        pop_c    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        push_c = mult_valid_i && clk_en_q && !bypass_c;
        pop_c  = valid_q && res_ready_i;

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        unique case ({push_c, pop_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        full_d   = (count_d == CNT_MAX);
        valid_d  = (count_d != '0);
        clk_en_d = (count_d != CNT_MAX);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            clk_en_q <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
            clk_en_q <= clk_en_d;
        end
    end

    // Storage is deliberately not reset; only pointers and occupancy are.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= mult_result_i;
        end
    end

    assign mult_clk_en_o = clk_en_q;
    assign full_o        = full_q;
    assign count_o       = count_q;
    assign res_valid_o   = valid_q || bypass_c;
    assign res_data_o    = bypass_c ? mult_result_i : mem_q[rd_ptr_q];

endmodule

// File: tb/tb_mul_result_buffer.sv
// Self-checking bench for mul_result_buffer: queue-based reference model plus directed scenarios.
// Expectations follow MUL_RESULT_BYPASS_EN when the bench is built with it.
module tb_mul_result_buffer;

    localparam int unsigned DW    = 16;
    localparam int unsigned PW    = 2 * DW;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef MUL_RESULT_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic [PW-1:0] mult_result_i = '0;
    logic          mult_valid_i = 1'b0;
    logic          mult_clk_en_o;
    logic [PW-1:0] res_data_o;
    logic          res_valid_o;
    logic          res_ready_i = 1'b0;
    logic [CW-1:0] count_o;
    logic          full_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: FIFO contents as a plain queue, front = oldest product.
    logic [PW-1:0] mq[$];

    always #5 clk = ~clk;

    mul_result_buffer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .mult_result_i(mult_result_i),
        .mult_valid_i (mult_valid_i),
        .mult_clk_en_o(mult_clk_en_o),
        .res_data_o   (res_data_o),
        .res_valid_o  (res_valid_o),
        .res_ready_i  (res_ready_i),
        .count_o      (count_o),
        .full_o       (full_o)
    );

    task automatic drive(input logic v, input logic [PW-1:0] d, input logic r);
        mult_valid_i  = v;
        mult_result_i = d;
        res_ready_i   = r;
    endtask

    // Step one clock edge and apply the FIFO rules to the model queue.
    task automatic advance();
        int n;
        bit byp;
        n = mq.size();
        @(posedge clk);
        byp = BYP && (n == 0) && mult_valid_i && res_ready_i;
        if (n != 0 && res_ready_i) void'(mq.pop_front());
        if (mult_valid_i && n < int'(DEPTH) && !byp) mq.push_back(mult_result_i);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0);
        rst_i = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        mq.delete();
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, PW'(32'hA000_0000 + k), 1'b0);
            advance();
        end
        drive(1'b0, '0, 1'b0);
        #2;
        tests_run++;
        if (count_o !== CW'(3)) begin
            tests_failed++;
            $display("FAIL reset_pre count: got %0d want 3", count_o);
        end
        rst_i = 1'b1;
        #1;
        tests_run++;
        if (count_o !== '0) begin
            tests_failed++;
            $display("FAIL reset count: got %0d want 0", count_o);
        end
        tests_run++;
        if (res_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset valid: got %b want 0", res_valid_o);
        end
        tests_run++;
        if (mult_clk_en_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset clk_en: got %b want 1", mult_clk_en_o);
        end
        tests_run++;
        if (full_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset full: got %b want 0", full_o);
        end
        mq.delete();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        drive(1'b1, PW'(32'h1234_5678), 1'b0);
        advance();
        drive(1'b0, '0, 1'b0);
        @(negedge clk);
        tests_run++;
        if (res_valid_o !== 1'b1 || res_data_o !== PW'(32'h1234_5678) || count_o !== CW'(1)) begin
            tests_failed++;
            $display("FAIL reset_recover: got v=%b d=%h c=%0d want v=1 d=12345678 c=1",
                     res_valid_o, res_data_o, count_o);
        end
        advance();
    endtask

    // mode 0 streaming, 1 backpressure, 2 pointer wrap, 3 random traffic.
    task automatic test_traffic(input int mode, input int ncyc, input int nprod, input string name);
        logic [PW-1:0] sent[$];
        logic [PW-1:0] recv[$];
        logic          v;
        logic          r;
        logic [PW-1:0] d;
        logic          hold;
        logic          exp_valid;
        logic [PW-1:0] exp_data;
        bit            byp;
        bit            acc;
        int            n;
        int            k;
        do_reset();
        v = 1'b0;
        d = '0;
        hold = 1'b0;
        k = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (!hold) begin
                case (mode)
                    0, 1:    v = (k < nprod);
                    2:       v = (k < nprod) && (i % 2 == 0);
                    default: v = (k < nprod) && ($urandom_range(0, 3) != 0);
                endcase
                d = (mode < 2) ? PW'(32'h0001_0000 + k) : PW'($urandom);
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = (i >= 8);
                2:       r = (i % 3 != 2);
                default: r = 1'($urandom_range(0, 1));
            endcase
            drive(v, d, r);
            @(negedge clk);
            n = mq.size();
            byp = BYP && (n == 0) && v && r;
            exp_valid = (n != 0) || byp;
            exp_data  = byp ? d : ((n != 0) ? mq[0] : '0);
            tests_run++;
            if (count_o !== CW'(n)) begin
                tests_failed++;
                $display("FAIL %s count cyc %0d: got %0d want %0d", name, i, count_o, n);
            end
            tests_run++;
            if (full_o !== (n == int'(DEPTH)) || mult_clk_en_o !== (n != int'(DEPTH))) begin
                tests_failed++;
                $display("FAIL %s full/clk_en cyc %0d: got %b/%b occupancy %0d",
                         name, i, full_o, mult_clk_en_o, n);
            end
            tests_run++;
            if (res_valid_o !== exp_valid) begin
                tests_failed++;
                $display("FAIL %s valid cyc %0d: got %b want %b", name, i, res_valid_o, exp_valid);
            end
            if (exp_valid) begin
                tests_run++;
                if (res_data_o !== exp_data) begin
                    tests_failed++;
                    $display("FAIL %s data cyc %0d: got %h want %h", name, i, res_data_o, exp_data);
                end
            end
            if (mode == 0 && i >= 1 && i <= 7) begin
                tests_run++;
                if (res_valid_o !== 1'b1 || count_o !== CW'(BYP ? 0 : 1)) begin
                    tests_failed++;
                    $display("FAIL %s steady cyc %0d: got v=%b c=%0d want v=1 c=%0d",
                             name, i, res_valid_o, count_o, BYP ? 0 : 1);
                end
            end
            if (mode == 1 && i == 4) begin
                tests_run++;
                if (full_o !== 1'b1 || mult_clk_en_o !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL %s fill: got full=%b en=%b want full=1 en=0",
                             name, full_o, mult_clk_en_o);
                end
            end
            if (res_valid_o === 1'b1 && r) recv.push_back(res_data_o);
            acc = v && (n < int'(DEPTH));
            if (acc) begin
                sent.push_back(d);
                k++;
            end
            hold = v && !acc;
            advance();
        end
        tests_run++;
        if ((mode < 3) ? (recv.size() != sent.size() || sent.size() != nprod)
                       : (recv.size() > sent.size())) begin
            tests_failed++;
            $display("FAIL %s delivered count: got %0d want %0d (offered %0d)",
                     name, recv.size(), sent.size(), nprod);
        end
        for (int j = 0; j < recv.size() && j < sent.size(); j++) begin
            tests_run++;
            if (recv[j] !== sent[j]) begin
                tests_failed++;
                $display("FAIL %s order idx %0d: got %h want %h", name, j, recv[j], sent[j]);
            end
        end
    endtask

    task automatic test_full_pop();
        logic [PW-1:0] p[5];
        for (int i = 0; i < 5; i++) p[i] = PW'(32'hC0DE_0000 + i);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, p[i], 1'b0);
            advance();
        end
        drive(1'b1, p[4], 1'b0);
        @(negedge clk);
        tests_run++;
        if (count_o !== CW'(4) || full_o !== 1'b1 || mult_clk_en_o !== 1'b0 || res_data_o !== p[0]) begin
            tests_failed++;
            $display("FAIL full_hold: got c=%0d f=%b en=%b d=%h want c=4 f=1 en=0 d=%h",
                     count_o, full_o, mult_clk_en_o, res_data_o, p[0]);
        end
        advance();
        drive(1'b1, p[4], 1'b1);
        @(negedge clk);
        tests_run++;
        if (count_o !== CW'(4) || mult_clk_en_o !== 1'b0 || res_valid_o !== 1'b1 || res_data_o !== p[0]) begin
            tests_failed++;
            $display("FAIL full_pop: got c=%0d en=%b v=%b d=%h want c=4 en=0 v=1 d=%h",
                     count_o, mult_clk_en_o, res_valid_o, res_data_o, p[0]);
        end
        advance();
        drive(1'b1, p[4], 1'b0);
        @(negedge clk);
        tests_run++;
        if (count_o !== CW'(3) || mult_clk_en_o !== 1'b1 || full_o !== 1'b0 || res_data_o !== p[1]) begin
            tests_failed++;
            $display("FAIL after_pop: got c=%0d en=%b f=%b d=%h want c=3 en=1 f=0 d=%h",
                     count_o, mult_clk_en_o, full_o, res_data_o, p[1]);
        end
        advance();
        drive(1'b0, '0, 1'b1);
        for (int j = 1; j <= 4; j++) begin
            @(negedge clk);
            tests_run++;
            if (count_o !== CW'(5 - j) || res_valid_o !== 1'b1 || res_data_o !== p[j]) begin
                tests_failed++;
                $display("FAIL drain %0d: got c=%0d v=%b d=%h want c=%0d v=1 d=%h",
                         j, count_o, res_valid_o, res_data_o, 5 - j, p[j]);
            end
            advance();
        end
        @(negedge clk);
        tests_run++;
        if (count_o !== '0 || res_valid_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL drained: got c=%0d v=%b want c=0 v=0", count_o, res_valid_o);
        end
        advance();
    endtask

    task automatic test_latency();
        do_reset();
        drive(1'b1, PW'(32'hDEAD_BEEF), 1'b1);
        @(negedge clk);
        tests_run++;
        if (BYP ? (res_valid_o !== 1'b1 || res_data_o !== PW'(32'hDEAD_BEEF) || count_o !== '0)
                : (res_valid_o !== 1'b0 || count_o !== '0)) begin
            tests_failed++;
            $display("FAIL latency_cyc0: got v=%b d=%h c=%0d bypass=%0d",
                     res_valid_o, res_data_o, count_o, BYP);
        end
        advance();
        drive(1'b0, '0, 1'b1);
        @(negedge clk);
        tests_run++;
        if (BYP ? (res_valid_o !== 1'b0 || count_o !== '0)
                : (res_valid_o !== 1'b1 || res_data_o !== PW'(32'hDEAD_BEEF) || count_o !== CW'(1))) begin
            tests_failed++;
            $display("FAIL latency_cyc1: got v=%b d=%h c=%0d bypass=%0d",
                     res_valid_o, res_data_o, count_o, BYP);
        end
        advance();
    endtask

    initial begin
        test_reset();
        test_traffic(0, 10, 8, "streaming");
        test_traffic(1, 20, 6, "backpressure");
        test_full_pop();
        test_traffic(2, 30, 10, "wrap");
        test_latency();
        test_traffic(3, 400, 250, "random");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
